// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronises the raw pin, filters bounce with a
// stability counter and publishes a clean level, press/release pulses and a press toggle.
module button_debouncer #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic BTN_CTRL,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_toggle
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_in;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   toggle_q, toggle_d;

  assign s_in = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      state_q  <= STABLE_LOW;
      count_q  <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], BTN_CTRL};
      state_q  <= state_d;
      count_q  <= count_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
    end
  end

  // Any sample agreeing with the current level drops back to the stable state,
  // so the full count restarts on the next disagreeing sample.
  always_comb begin
    state_d  = state_q;
    count_d  = '0;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    toggle_d = toggle_q;
    case (state_q)
      STABLE_LOW: begin
        level_d = 1'b0;
        if (s_in) begin
          state_d = CHECK_HIGH;
          count_d = CNT_ONE;
        end
      end
      CHECK_HIGH: begin
        level_d = 1'b0;
        if (!s_in) begin
          state_d = STABLE_LOW;
        end else if (count_q == CNT_LAST) begin
          state_d  = STABLE_HIGH;
          level_d  = 1'b1;
          rise_d   = 1'b1;
          toggle_d = ~toggle_q;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        level_d = 1'b1;
        if (!s_in) begin
          state_d = CHECK_LOW;
          count_d = CNT_ONE;
        end
      end
      CHECK_LOW: begin
        level_d = 1'b1;
        if (s_in) begin
          state_d = STABLE_HIGH;
        end else if (count_q == CNT_LAST) begin
          state_d = STABLE_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      default: begin
        state_d  = STABLE_LOW;
        level_d  = 1'b0;
        toggle_d = 1'b0;
      end
    endcase
  end

  assign btn_level  = level_q;
  assign btn_rise   = rise_q;
  assign btn_fall   = fall_q;
  assign btn_toggle = toggle_q;

endmodule
